// File: rtl/fpga_rst_seq_if.sv
// Reset-sequencer signal bundle.
// master: the sequencer itself (samples requests/calibration, drives resets).
// slave : the surrounding board logic (drives requests, consumes resets).
interface fpga_rst_seq_if;
  logic       btn_i;          // board reset button, asynchronous, polarity by parameter
  logic       vio_rst_i;      // debug reset request, synchronous level
  logic       calib_done_i;   // DRAM calibration complete, DRAM clock domain
  logic       dram_rst_o;     // active-high memory-controller system reset
  logic       periph_rst_no;  // active-low peripheral/fan reset
  logic       soc_rst_no;     // active-low SoC reset
  logic       fail_o;         // calibration gave up
  logic [1:0] retries_o;      // failed attempts this sequence, saturating
  logic [2:0] state_o;        // sequencer state

  modport master (
    input  btn_i,
    input  vio_rst_i,
    input  calib_done_i,
    output dram_rst_o,
    output periph_rst_no,
    output soc_rst_no,
    output fail_o,
    output retries_o,
    output state_o
  );

  modport slave (
    output btn_i,
    output vio_rst_i,
    output calib_done_i,
    input  dram_rst_o,
    input  periph_rst_no,
    input  soc_rst_no,
    input  fail_o,
    input  retries_o,
    input  state_o
  );
endinterface

// File: rtl/fpga_rst_seq.sv
// FPGA top reset sequencer.
// Runs on the free-running board oscillator. Holds the memory controller in
// reset, waits for DRAM calibration (with timeout and bounded retry), then
// releases the peripheral reset and, a fixed gap later, the SoC reset.
// Button and debug requests restart the whole sequence from any state.
module fpga_rst_seq #(
  parameter logic        BtnActiveLow       = 1'b0,
  parameter int unsigned DebounceCycles     = 16,
  parameter int unsigned MinAssertCycles    = 64,
  parameter int unsigned ReleaseGapCycles   = 16,
  parameter int unsigned CalibTimeoutCycles = 2**24,
  parameter int unsigned MaxRetries         = 3
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  fpga_rst_seq_if.master bus
);

  // ---------------------------------------------------------------------------
  // Derived widths
  // ---------------------------------------------------------------------------
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MaxCount = max_u(max_u(max_u(DebounceCycles, MinAssertCycles),
                                                 max_u(ReleaseGapCycles, CalibTimeoutCycles)),
                                           MaxRetries);
  // One spare bit so no terminal count ever sits on the top code.
  localparam int unsigned CntWidth = $clog2(MaxCount) + 1;
  localparam int unsigned RetWidth = (MaxRetries < 2) ? 1 : $clog2(MaxRetries + 1);

  localparam logic [CntWidth-1:0] DebMax    = CntWidth'(DebounceCycles);
  localparam logic [CntWidth-1:0] HoldLast  = CntWidth'(MinAssertCycles - 1);
  localparam logic [CntWidth-1:0] CalibLast = CntWidth'(CalibTimeoutCycles - 1);
  localparam logic [CntWidth-1:0] GapLast   = CntWidth'(ReleaseGapCycles - 1);
  localparam logic [RetWidth-1:0] RetLimit  = RetWidth'(MaxRetries);

  typedef enum logic [2:0] {
    ST_RESET_HOLD = 3'd0,
    ST_WAIT_CALIB = 3'd1,
    ST_PERIPH_REL = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAIL       = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------
  // The button idles at its deasserted level so a reset never looks like a press.
  logic [1:0] r_btn_sync;
  logic [1:0] r_calib_sync;
  logic       w_btn_asserted;
  logic       w_calib_done;

  // Two-flop synchronisers for the button and the DRAM-domain calibration flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_btn_sync   <= {2{BtnActiveLow}};
      r_calib_sync <= 2'b00;
    end else begin
      r_btn_sync   <= {r_btn_sync[0], bus.btn_i};
      r_calib_sync <= {r_calib_sync[0], bus.calib_done_i};
    end
  end

  // Normalise polarity: high means "button pressed".
  assign w_btn_asserted = r_btn_sync[1] ^ BtnActiveLow;
  assign w_calib_done   = r_calib_sync[1];

  // ---------------------------------------------------------------------------
  // Button debounce
  // ---------------------------------------------------------------------------
  logic [CntWidth-1:0] r_deb_cnt;
  logic                w_btn_req;
  logic                w_req;

  // Count consecutive pressed cycles, saturating at the debounce length.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_deb_cnt <= '0;
    end else if (!w_btn_asserted) begin
      r_deb_cnt <= '0;
    end else if (r_deb_cnt != DebMax) begin
      r_deb_cnt <= r_deb_cnt + CntWidth'(1);
    end
  end

  // A debounced press and a debug request are equivalent restart requests.
  assign w_btn_req = (r_deb_cnt == DebMax);
  assign w_req     = w_btn_req | bus.vio_rst_i;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  state_e              r_state;
  logic [CntWidth-1:0] r_timer;
  logic [RetWidth-1:0] r_retries;
  logic                r_dram_rst;
  logic                r_periph_rstn;
  logic                r_soc_rstn;
  logic                r_fail;
  logic [1:0]          r_retries_o;

  state_e              w_state_next;
  logic [CntWidth-1:0] w_timer_next;
  logic [RetWidth-1:0] w_retries_next;
  logic [RetWidth-1:0] w_retries_inc;
  logic [1:0]          w_retries_sat;

  assign w_retries_inc = r_retries + RetWidth'(1);

  // Next-state, timer and retry bookkeeping. A restart request beats every
  // other transition; the timer restarts at zero on every state change and is
  // parked at zero in states that do not time anything, so it never wraps.
  always_comb begin
    w_state_next   = r_state;
    w_timer_next   = r_timer + CntWidth'(1);
    w_retries_next = r_retries;
    if (w_req) begin
      w_state_next   = ST_RESET_HOLD;
      w_timer_next   = '0;
      w_retries_next = '0;
    end else begin
      case (r_state)
        ST_RESET_HOLD: begin
          if (r_timer == HoldLast) begin
            w_state_next = ST_WAIT_CALIB;
            w_timer_next = '0;
          end
        end
        ST_WAIT_CALIB: begin
          // Calibration arriving on the timeout cycle still counts as success.
          if (w_calib_done) begin
            w_state_next = ST_PERIPH_REL;
            w_timer_next = '0;
          end else if (r_timer == CalibLast) begin
            w_retries_next = w_retries_inc;
            w_timer_next   = '0;
            w_state_next   = (w_retries_inc == RetLimit) ? ST_FAIL : ST_RESET_HOLD;
          end
        end
        ST_PERIPH_REL: begin
          // Losing calibration here is not a failed attempt, just a restart.
          if (!w_calib_done) begin
            w_state_next = ST_RESET_HOLD;
            w_timer_next = '0;
          end else if (r_timer == GapLast) begin
            w_state_next = ST_RUN;
            w_timer_next = '0;
          end
        end
        ST_RUN: begin
          w_timer_next = '0;
          if (!w_calib_done) begin
            w_state_next = ST_RESET_HOLD;
          end
        end
        ST_FAIL: begin
          // Sticky until a restart request or a power-on reset.
          w_timer_next = '0;
        end
        default: begin
          w_state_next = ST_RESET_HOLD;
          w_timer_next = '0;
        end
      endcase
    end
  end

  // Reported retry count saturates at 3 when the limit needs more bits.
  generate
    if (RetWidth <= 2) begin : gen_ret_narrow
      assign w_retries_sat = 2'(w_retries_next);
    end else begin : gen_ret_wide
      assign w_retries_sat = (w_retries_next > RetWidth'(3)) ? 2'd3 : w_retries_next[1:0];
    end
  endgenerate

  // State register plus outputs decoded from the next state, so every reset
  // output changes in the same cycle as the state it belongs to and all of
  // them assert together on entry to RESET_HOLD.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= ST_RESET_HOLD;
      r_timer       <= '0;
      r_retries     <= '0;
      r_dram_rst    <= 1'b1;
      r_periph_rstn <= 1'b0;
      r_soc_rstn    <= 1'b0;
      r_fail        <= 1'b0;
      r_retries_o   <= 2'd0;
    end else begin
      r_state       <= w_state_next;
      r_timer       <= w_timer_next;
      r_retries     <= w_retries_next;
      r_dram_rst    <= (w_state_next == ST_RESET_HOLD) || (w_state_next == ST_FAIL);
      r_periph_rstn <= (w_state_next == ST_PERIPH_REL) || (w_state_next == ST_RUN);
      r_soc_rstn    <= (w_state_next == ST_RUN);
      r_fail        <= (w_state_next == ST_FAIL);
      r_retries_o   <= w_retries_sat;
    end
  end

  assign bus.dram_rst_o    = r_dram_rst;
  assign bus.periph_rst_no = r_periph_rstn;
  assign bus.soc_rst_no    = r_soc_rstn;
  assign bus.fail_o        = r_fail;
  assign bus.retries_o     = r_retries_o;
  assign bus.state_o       = r_state;

endmodule

// File: tb/tb_fpga_rst_seq.sv
// Self-checking bench for fpga_rst_seq. Each scenario pushes the state
// transitions it expects onto a scoreboard; a monitor pops one entry per
// observed state change and checks state and all outputs against it.
module tb_fpga_rst_seq;

  localparam logic [2:0] S_HOLD = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_PREL = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_FAIL = 3'd4;

  typedef struct {
    logic [2:0] st;
    logic [1:0] ret;
  } exp_t;

  logic clk_i;
  logic rst_ni;
  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];
  logic [2:0] prev_state;

  fpga_rst_seq_if u_if ();

  fpga_rst_seq #(
    .BtnActiveLow      (1'b0),
    .DebounceCycles    (4),
    .MinAssertCycles   (8),
    .ReleaseGapCycles  (3),
    .CalibTimeoutCycles(100),
    .MaxRetries        (2)
  ) u_dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (u_if)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic [1:0] ret);
    exp_t e;
    e.st  = st;
    e.ret = ret;
    sb_q.push_back(e);
  endtask

  task automatic wait_state(input logic [2:0] st, input int max_cyc, input string tag,
                            output int n);
    n = 0;
    while (u_if.state_o != st && n < max_cyc) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_reached"}, 32'(u_if.state_o == st), 32'd1);
  endtask

  // Scoreboard monitor: one line and one scoreboard entry per state change.
  initial prev_state = S_HOLD;
  always @(negedge clk_i) begin
    exp_t e;
    if (u_if.state_o != prev_state) begin
      $display("[%0t] state %0d -> %0d dram=%0b periph_n=%0b soc_n=%0b fail=%0b retries=%0d",
               $time, prev_state, u_if.state_o, u_if.dram_rst_o, u_if.periph_rst_no,
               u_if.soc_rst_no, u_if.fail_o, u_if.retries_o);
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_transition", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk("sb_state",   32'(u_if.state_o),       32'(e.st));
        chk("sb_dram",    32'(u_if.dram_rst_o),    32'(e.st == S_HOLD || e.st == S_FAIL));
        chk("sb_periph",  32'(u_if.periph_rst_no), 32'(e.st == S_PREL || e.st == S_RUN));
        chk("sb_soc",     32'(u_if.soc_rst_no),    32'(e.st == S_RUN));
        chk("sb_fail",    32'(u_if.fail_o),        32'(e.st == S_FAIL));
        chk("sb_retries", 32'(u_if.retries_o),     32'(e.ret));
      end
      prev_state <= u_if.state_o;
    end
  end

  // Hard stop if the run ever stalls.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n_assert;
    n_checks = 0;
    n_errors = 0;
    rst_ni            = 1'b0;
    u_if.btn_i        = 1'b0;
    u_if.vio_rst_i    = 1'b0;
    u_if.calib_done_i = 1'b1;
    repeat (3) @(negedge clk_i);

    // Reset values
    chk("rst_state",   32'(u_if.state_o),       32'd0);
    chk("rst_dram",    32'(u_if.dram_rst_o),    32'd1);
    chk("rst_periph",  32'(u_if.periph_rst_no), 32'd0);
    chk("rst_soc",     32'(u_if.soc_rst_no),    32'd0);
    chk("rst_fail",    32'(u_if.fail_o),        32'd0);
    chk("rst_retries", 32'(u_if.retries_o),     32'd0);

    // Power-up with calibration already done
    push(S_WAIT, 2'd0); push(S_PREL, 2'd0); push(S_RUN, 2'd0);
    rst_ni = 1'b1;
    wait_state(S_WAIT, 50, "pwr_wait", n);
    chk("pwr_dram_fall_cyc", 32'(n), 32'd8);
    wait_state(S_PREL, 50, "pwr_prel", n);
    chk("pwr_periph_lat_in_range", 32'(n >= 1 && n <= 3), 32'd1);
    wait_state(S_RUN, 50, "pwr_run", n);
    chk("pwr_soc_gap", 32'(n), 32'd3);
    chk("pwr_state_run", 32'(u_if.state_o), 32'(S_RUN));

    // 3-cycle button glitch: must not restart
    u_if.btn_i = 1'b1;
    repeat (3) @(negedge clk_i);
    u_if.btn_i = 1'b0;
    repeat (12) @(negedge clk_i);
    chk("glitch_still_run", 32'(u_if.state_o), 32'(S_RUN));

    // 6-cycle press: restart after sync(2) + debounce(4) + 1
    push(S_HOLD, 2'd0); push(S_WAIT, 2'd0); push(S_PREL, 2'd0); push(S_RUN, 2'd0);
    u_if.btn_i = 1'b1;
    n_assert = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (i == 5) u_if.btn_i = 1'b0;
      if (u_if.dram_rst_o && n_assert == 0) n_assert = i + 1;
    end
    chk("btn_assert_lat", 32'(n_assert), 32'd7);
    wait_state(S_RUN, 100, "btn_rerun", n);

    // Calibration lost for 3 cycles in RUN
    push(S_HOLD, 2'd0); push(S_WAIT, 2'd0); push(S_PREL, 2'd0); push(S_RUN, 2'd0);
    u_if.calib_done_i = 1'b0;
    n_assert = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      if (u_if.dram_rst_o && n_assert == 0) n_assert = i + 1;
    end
    u_if.calib_done_i = 1'b1;
    chk("lost_assert_lat", 32'(n_assert), 32'd3);
    chk("lost_retries", 32'(u_if.retries_o), 32'd0);
    wait_state(S_RUN, 100, "lost_rerun", n);

    // Calibration timeout twice -> FAIL
    push(S_HOLD, 2'd0); push(S_WAIT, 2'd0); push(S_HOLD, 2'd1); push(S_WAIT, 2'd1);
    push(S_FAIL, 2'd2);
    u_if.calib_done_i = 1'b0;
    wait_state(S_WAIT, 50, "to_wait1", n);
    wait_state(S_HOLD, 200, "to_hold2", n);
    chk("to_timeout_cyc1", 32'(n), 32'd100);
    chk("to_retries1", 32'(u_if.retries_o), 32'd1);
    wait_state(S_WAIT, 50, "to_wait2", n);
    wait_state(S_FAIL, 200, "to_fail", n);
    chk("to_timeout_cyc2", 32'(n), 32'd100);
    chk("to_fail_flag", 32'(u_if.fail_o), 32'd1);
    chk("to_fail_dram", 32'(u_if.dram_rst_o), 32'd1);
    chk("to_retries2", 32'(u_if.retries_o), 32'd2);
    repeat (20) @(negedge clk_i);
    chk("fail_sticky", 32'(u_if.state_o), 32'(S_FAIL));

    // VIO pulse clears FAIL; late calibration on attempt 2
    push(S_HOLD, 2'd0); push(S_WAIT, 2'd0); push(S_HOLD, 2'd1); push(S_WAIT, 2'd1);
    push(S_PREL, 2'd1); push(S_RUN, 2'd1);
    u_if.vio_rst_i = 1'b1;
    @(negedge clk_i);
    u_if.vio_rst_i = 1'b0;
    chk("vio_clr_fail", 32'(u_if.fail_o), 32'd0);
    chk("vio_clr_retries", 32'(u_if.retries_o), 32'd0);
    wait_state(S_WAIT, 50, "late_wait1", n);
    wait_state(S_HOLD, 200, "late_hold2", n);
    wait_state(S_WAIT, 50, "late_wait2", n);
    repeat (48) @(negedge clk_i);
    u_if.calib_done_i = 1'b1;
    wait_state(S_RUN, 100, "late_run", n);
    chk("late_retries", 32'(u_if.retries_o), 32'd1);
    chk("late_fail", 32'(u_if.fail_o), 32'd0);

    // Asynchronous reset while in PERIPH_REL
    push(S_HOLD, 2'd0); push(S_WAIT, 2'd0); push(S_PREL, 2'd0); push(S_HOLD, 2'd0);
    u_if.vio_rst_i = 1'b1;
    @(negedge clk_i);
    u_if.vio_rst_i = 1'b0;
    wait_state(S_PREL, 50, "mid_prel", n);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_state",  32'(u_if.state_o),       32'd0);
    chk("async_dram",   32'(u_if.dram_rst_o),    32'd1);
    chk("async_periph", 32'(u_if.periph_rst_no), 32'd0);
    chk("async_soc",    32'(u_if.soc_rst_no),    32'd0);
    repeat (3) @(negedge clk_i);

    // VIO held 20 cycles: stay in RESET_HOLD, then 8 cycles to release
    u_if.vio_rst_i = 1'b1;
    rst_ni = 1'b1;
    repeat (20) @(negedge clk_i);
    chk("vio_hold_state", 32'(u_if.state_o), 32'd0);
    chk("vio_hold_dram", 32'(u_if.dram_rst_o), 32'd1);
    push(S_WAIT, 2'd0); push(S_PREL, 2'd0); push(S_RUN, 2'd0);
    u_if.vio_rst_i = 1'b0;
    wait_state(S_WAIT, 50, "vio_wait", n);
    chk("vio_release_cyc", 32'(n), 32'd8);
    wait_state(S_RUN, 50, "vio_run", n);

    repeat (3) @(negedge clk_i);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
